mont_exp_seq: RTL and testbench
===============================

# mont_exp_seq

Hardware exponent sequencer for the RSA coprocessor. It replaces the per-bit software loop that today issues every Montgomery multiplication over AXI-lite. Given an exponent and its bit length, it walks the bits MSB-first with the Montgomery ladder and issues the full operation sequence to the Montgomery multiplier through a start/done handshake. The width is parametrised and the sequencer supports abort; software writes one command and polls one status bit.

## Interface
- `E_WIDTH`, default 1024: maximum exponent width in bits.
- `LEN_W`, default `$clog2(E_WIDTH+1)`: width of the length and step fields.
- `clk` in 1: single clock for the block.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: sampled only in IDLE; launches an exponentiation.
- `abort` in 1: cancels any operation in progress.
- `exp` in E_WIDTH: exponent; only bits `[exp_len-1:0]` are used.
- `exp_len` in LEN_W: number of exponent bits to process, from 0 to E_WIDTH.
- `mul_start` out 1: single-cycle request to the multiplier.
- `mul_op` out 3: operation code, held stable from `mul_start` until `mul_done`.
- `mul_abort` out 1: single-cycle pulse telling the multiplier to drop its current operation.
- `mul_done` in 1: single-cycle completion pulse from the multiplier.
- `busy` out 1: high while a sequence is in progress.
- `done` out 1: single-cycle pulse when a sequence completes.
- `err` out 1: sticky; set when `exp_len > E_WIDTH` at start; cleared by the next accepted start.
- `step` out LEN_W: index of the bit currently being processed.
- `mul_count` out 16: number of multiplications completed in the current or last sequence.

## Operation
- **Operation codes:**
  - OP_INIT_X = 0: X ← MM(M, R²).
  - OP_AX_A = 1: A ← MM(A, X).
  - OP_XX_X = 2: X ← MM(X, X).
  - OP_AX_X = 3: X ← MM(A, X).
  - OP_AA_A = 4: A ← MM(A, A).
  - OP_FINAL = 5: A ← MM(A, 1).
- The A register is preloaded with R mod N by loading logic outside this block.
- **States:** IDLE, ISSUE, WAIT, DONE.
- **Transitions:**
  - IDLE → ISSUE on `start` with a legal `exp_len`. On entry, latch `exp` and `exp_len`, set `step = exp_len-1`, clear `mul_count` and `err`, and queue OP_INIT_X.
  - ISSUE → WAIT unconditionally. `mul_start` is high for exactly this one cycle.
  - WAIT → ISSUE on `mul_done` when more operations remain; `mul_count` increments.
  - WAIT → DONE on the `mul_done` of OP_FINAL.
  - DONE → IDLE after one cycle.
- **Bit walk:** after INIT, each bit b = `exp[step]` issues two operations.
  - b = 1: OP_AX_A, then OP_XX_X.
  - b = 0: OP_AX_X, then OP_AA_A.
  - After the second operation, `step` decrements. When the step being processed was 0, the next operation is OP_FINAL.
- **Operation count:** always 2 + 2·`exp_len`, independent of exponent value (constant-time). Leading zeros are not skipped.
- **`exp_len` = 0:** issues OP_INIT_X and OP_FINAL only.
- **`exp_len` > E_WIDTH:** set `err`, stay in IDLE, issue nothing, no `done`.
- **`start` while busy:** ignored. Latched operands do not change.
- **`abort`:** in ISSUE or WAIT, go to IDLE next cycle. Pulse `mul_abort` if a multiply is outstanding. No `done`. `mul_count` holds. A later `mul_done` is ignored.
- **`abort` in IDLE or DONE:** no effect; `done` still pulses.
- **`mul_done` in IDLE or ISSUE:** ignored, and does not increment `mul_count`.
- **Simultaneous `abort` and `mul_done`:** abort wins; `mul_count` is not incremented.

## Timing
- **Reset values:** state IDLE; `mul_start`, `mul_abort`, `busy`, `done`, `err` = 0; `mul_op` = 0; `step` = 0; `mul_count` = 0.
- `rst` takes priority over every input and aborts mid-sequence silently (no `mul_abort`).
- **Start latency:** `start` sampled at edge T gives `busy` = 1 and `mul_start` = 1 with OP_INIT_X during cycle T+1.
- **Issue latency:** `mul_done` in cycle D gives the next `mul_start` in cycle D+2 (WAIT → ISSUE takes one edge). `mul_done` is legal at the earliest in the cycle after `mul_start`.
- **Completion:** the `mul_done` of OP_FINAL in cycle D gives `done` = 1 and `busy` = 0 in cycle D+1.
- **Total latency:** sum of multiplier latencies plus 2 cycles per operation, plus 1.
- `mul_op` and `step` are registered outputs. `mul_op` is valid from ISSUE through WAIT.

## Structure
- Package `mont_exp_pkg`: OP_* localparams, the state enum, and the 3-bit op width.
- Sub-module `mont_exp_bitsel`: registered MSB-first bit selector producing the `exp[step]` mux. It is isolated to keep the 1024:1 mux off the FSM's critical path.
- Everything else lives in a single module.

## Test plan
- `exp` = 0x9985, `exp_len` = 16, multiplier latency 5:
  - 34 `mul_start` pulses.
  - Op stream: 0, then per bit MSB-first (1,0,0,1,1,0,0,1,1,0,0,0,0,1,0,1), (1,2) for a 1 and (3,4) for a 0, then 5.
  - `done` occurs once and `mul_count` = 34.
- `exp_len` = 0: ops 0 then 5 only, `mul_count` = 2, `done` 1 cycle after the second `mul_done`.
- `exp_len` = E_WIDTH+1: `err` = 1, no `mul_start`, `busy` stays 0. A following legal start clears `err`.
- Abort during WAIT of the 7th op:
  - `mul_abort` pulse and `busy` = 0 the next cycle.
  - The late `mul_done` is ignored, `mul_count` = 6, no `done`.
- Simultaneous `abort` and `mul_done`: no increment and no further `mul_start`.
- `start` pulsed mid-sequence and `rst` asserted mid-sequence:
  - The `start` pulse is ignored and the op stream is unchanged.
  - `rst` returns all outputs to reset values next cycle.

Source files
------------

// File: rtl/mont_exp_pkg.sv
// mont_exp_pkg: shared op codes and FSM state for the Montgomery exponent sequencer
package mont_exp_pkg;
  localparam int OP_W = 3;
  localparam logic [OP_W-1:0] OP_INIT_X = 3'd0;
  localparam logic [OP_W-1:0] OP_AX_A   = 3'd1;
  localparam logic [OP_W-1:0] OP_XX_X   = 3'd2;
  localparam logic [OP_W-1:0] OP_AX_X   = 3'd3;
  localparam logic [OP_W-1:0] OP_AA_A   = 3'd4;
  localparam logic [OP_W-1:0] OP_FINAL  = 3'd5;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/mont_exp_bitsel.sv
// mont_exp_bitsel: latches the exponent and registers the wide exp[idx] mux
module mont_exp_bitsel #(
  parameter int E_WIDTH = 1024,
  parameter int LEN_W = $clog2(E_WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [E_WIDTH-1:0] exp,
  input  logic [LEN_W-1:0]   idx,
  output logic               bit_val
);
  localparam int IW = $clog2(E_WIDTH);
  logic [E_WIDTH-1:0] exp_q;
  // capture operand on accepted start; out-of-range indices read as zero
  always_ff @(posedge clk)
    if (rst) begin
      exp_q   <= '0;
      bit_val <= 1'b0;
    end else begin
      if (load) exp_q <= exp;
      bit_val <= idx < LEN_W'(E_WIDTH) ? exp_q[idx[IW-1:0]] : 1'b0;
    end
endmodule

// File: rtl/mont_exp_seq.sv
// mont_exp_seq: Montgomery-ladder exponent sequencer driving a Montgomery multiplier
module mont_exp_seq
  import mont_exp_pkg::*;
#(
  parameter int E_WIDTH = 1024,
  parameter int LEN_W = $clog2(E_WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [E_WIDTH-1:0] exp,
  input  logic [LEN_W-1:0]   exp_len,
  output logic               mul_start,
  output logic [OP_W-1:0]    mul_op,
  output logic               mul_abort,
  input  logic               mul_done,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [LEN_W-1:0]   step,
  output logic [15:0]        mul_count
);
  state_t state;
  logic pend, len_zero, b, second, more, load;
  logic [LEN_W-1:0] idx;
  logic [OP_W-1:0] next_op;
  assign load = state == S_IDLE && start && exp_len <= LEN_W'(E_WIDTH);
  assign second = mul_op == OP_XX_X || mul_op == OP_AA_A;
  // after the second op of a bit the selector must already look at the next lower bit
  assign idx = second ? step - LEN_W'(1) : step;
  assign more = second ? step != '0 : mul_op == OP_INIT_X && !len_zero;
  mont_exp_bitsel #(.E_WIDTH(E_WIDTH), .LEN_W(LEN_W)) u_bitsel (
    .clk(clk),
    .rst(rst),
    .load(load),
    .exp(exp),
    .idx(idx),
    .bit_val(b)
  );
  // op that follows the current one in the ladder
  always_comb
    next_op = mul_op == OP_AX_A ? OP_XX_X :
              mul_op == OP_AX_X ? OP_AA_A :
              more ? (b ? OP_AX_A : OP_AX_X) : OP_FINAL;
  // sequencer FSM; pend adds the settle cycle between mul_done and the next issue
  always_ff @(posedge clk)
    if (rst) begin
      state     <= S_IDLE;
      mul_start <= 1'b0;
      mul_abort <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mul_op    <= OP_INIT_X;
      step      <= '0;
      mul_count <= '0;
      pend      <= 1'b0;
      len_zero  <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      mul_abort <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE:
          if (load) begin
            state     <= S_ISSUE;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            err       <= 1'b0;
            mul_op    <= OP_INIT_X;
            step      <= exp_len - LEN_W'(1);
            mul_count <= '0;
            pend      <= 1'b0;
            len_zero  <= exp_len == '0;
          end else if (start) err <= 1'b1;
        S_ISSUE:
          if (abort) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            mul_abort <= 1'b1;
          end else state <= S_WAIT;
        S_WAIT:
          if (abort) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            mul_abort <= !pend && !mul_done;
          end else if (pend) begin
            state     <= S_ISSUE;
            mul_start <= 1'b1;
            pend      <= 1'b0;
          end else if (mul_done) begin
            mul_count <= mul_count + 16'd1;
            if (mul_op == OP_FINAL) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              pend   <= 1'b1;
              mul_op <= next_op;
              if (second && step != '0) step <= step - LEN_W'(1);
            end
          end
        S_DONE: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mont_exp_seq.sv
// tb_mont_exp_seq: directed checks of the exponent sequencer against a latency-5 multiplier model
module tb_mont_exp_seq;
  localparam int E_WIDTH = 16;
  localparam int LEN_W = $clog2(E_WIDTH + 1);
  logic clk = 0, rst = 1, start = 0, abort = 0, mul_done = 0;
  logic [E_WIDTH-1:0] exp = '0;
  logic [LEN_W-1:0] exp_len = '0;
  logic mul_start, mul_abort, busy, done, err;
  logic [2:0] mul_op;
  logic [LEN_W-1:0] step;
  logic [15:0] mul_count;
  int n_chk = 0, n_pass = 0;
  int ops[$];
  int n_done = 0, cyc = 0, timer = 0, last_md = -1, done_lat = -1;
  int gap_min = 1000, gap_max = -1;
  int lat = 5;
  int base;
  int exp_ops[34] = '{0, 1,2, 3,4, 3,4, 1,2, 1,2, 3,4, 3,4, 1,2, 1,2,
                      3,4, 3,4, 3,4, 3,4, 1,2, 3,4, 1,2, 5};
  mont_exp_seq #(.E_WIDTH(E_WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .exp(exp), .exp_len(exp_len),
    .mul_start(mul_start), .mul_op(mul_op), .mul_abort(mul_abort), .mul_done(mul_done),
    .busy(busy), .done(done), .err(err), .step(step), .mul_count(mul_count)
  );
  always #5 clk = ~clk;
  // multiplier model: mul_done lat cycles after each mul_start, keeps running after aborts
  always @(negedge clk) begin
    cyc++;
    mul_done = 0;
    if (done) begin
      n_done++;
      done_lat = cyc - last_md;
    end
    if (mul_start) begin
      ops.push_back(int'(mul_op));
      if (last_md >= 0) begin
        if (cyc - last_md < gap_min) gap_min = cyc - last_md;
        if (cyc - last_md > gap_max) gap_max = cyc - last_md;
      end
    end
    if (timer > 0) begin
      timer--;
      if (timer == 0) begin
        mul_done = 1;
        last_md = cyc;
      end
    end
    if (mul_start) timer = lat;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) $display("FAIL %s: got %0d expected %0d", tag, got, want);
    else n_pass++;
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic wait_done(input int b);
    for (int i = 0; i < 2000 && n_done == b; i++) tick(1);
    check("done_seen", n_done, b + 1);
  endtask
  task automatic go(input logic [E_WIDTH-1:0] e, input logic [LEN_W-1:0] l);
    exp = e;
    exp_len = l;
    start = 1;
    tick(1);
    start = 0;
  endtask
  initial begin
    tick(3);
    rst = 0;
    tick(1);
    check("rst_busy", busy, 0);
    check("rst_flags", {mul_start, mul_abort, done, err}, 0);
    check("rst_op", mul_op, 0);
    check("rst_step", step, 0);
    check("rst_count", mul_count, 0);
    // full 16-bit exponent, with a start pulse and operand change mid-sequence
    ops.delete();
    base = n_done;
    go(16'h9985, 16);
    check("start_busy", busy, 1);
    check("start_mul_start", mul_start, 1);
    check("start_op", mul_op, 0);
    check("start_step", step, 15);
    tick(20);
    go(16'h0000, 3);
    exp = 16'h00ff;
    wait_done(base);
    check("busy_after_done", busy, 0);
    check("count_34", mul_count, 34);
    check("n_ops_34", ops.size(), 34);
    for (int i = 0; i < 34 && i < ops.size(); i++) check($sformatf("op%0d", i), ops[i], exp_ops[i]);
    check("issue_gap_min", gap_min, 2);
    check("issue_gap_max", gap_max, 2);
    check("done_lat", done_lat, 1);
    tick(3);
    check("done_once", n_done, base + 1);
    // zero-length exponent
    ops.delete();
    base = n_done;
    go(16'hffff, 0);
    wait_done(base);
    check("len0_n_ops", ops.size(), 2);
    if (ops.size() == 2) begin
      check("len0_op0", ops[0], 0);
      check("len0_op1", ops[1], 5);
    end
    check("len0_count", mul_count, 2);
    check("len0_done_lat", done_lat, 1);
    // over-length exponent, then a legal start clears err
    tick(3);
    ops.delete();
    base = n_done;
    go(16'hffff, 17);
    check("bad_err", err, 1);
    check("bad_busy", busy, 0);
    tick(10);
    check("bad_no_start", ops.size(), 0);
    check("bad_busy_late", busy, 0);
    check("bad_no_done", n_done, base);
    go(16'h0001, 1);
    check("err_cleared", err, 0);
    wait_done(base);
    check("len1_n_ops", ops.size(), 4);
    if (ops.size() == 4) check("len1_ops", {ops[0][7:0], ops[1][7:0], ops[2][7:0], ops[3][7:0]}, 32'h00010205);
    check("len1_count", mul_count, 4);
    // abort during WAIT of the 7th op
    tick(3);
    ops.delete();
    base = n_done;
    go(16'h9985, 16);
    for (int i = 0; i < 500 && ops.size() < 7; i++) tick(1);
    tick(1);
    abort = 1;
    tick(1);
    abort = 0;
    check("abort_mul_abort", mul_abort, 1);
    check("abort_busy", busy, 0);
    tick(12);
    check("abort_count", mul_count, 6);
    check("abort_no_done", n_done, base);
    check("abort_no_start", ops.size(), 7);
    // abort coinciding with mul_done of the 3rd op
    ops.delete();
    go(16'h9985, 16);
    for (int i = 0; i < 500 && ops.size() < 3; i++) tick(1);
    for (int i = 0; i < 50 && !mul_done; i++) tick(1);
    abort = 1;
    tick(1);
    abort = 0;
    check("sim_count", mul_count, 2);
    check("sim_busy", busy, 0);
    tick(15);
    check("sim_no_start", ops.size(), 3);
    check("sim_no_done", n_done, base);
    // reset mid-sequence
    ops.delete();
    go(16'h9985, 16);
    tick(20);
    rst = 1;
    tick(1);
    rst = 0;
    check("mrst_busy", busy, 0);
    check("mrst_flags", {mul_start, mul_abort, done, err}, 0);
    check("mrst_op", mul_op, 0);
    check("mrst_step", step, 0);
    check("mrst_count", mul_count, 0);
    tick(10);
    check("idle_done_ignored", mul_count, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
